// File: rtl/cache_chk_pkg.sv
// Shared types and defaults for the cache channel protocol checker.
//   chk_state_e : per-lane handshake FSM state
//   chk_err_e   : error codes reported in the first-error record
package cache_chk_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } chk_state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_DROP = 2'd1,
        ERR_PLD  = 2'd2,
        ERR_TMO  = 2'd3
    } chk_err_e;

    localparam int DEF_NUM_CH    = 8;
    localparam int DEF_PLD_WIDTH = 64;
    localparam int DEF_CNT_WIDTH = 16;
    localparam int DEF_MAX_WAIT  = 256;

    // $clog2 that never returns 0, so a single-entry index still has a bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_chan_chk_lane.sv
// One monitored channel: handshake FSM, stall wait counter, payload capture,
// saturating transaction counter and the three sticky error bits.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   i_chk_en             checking enable (0 forces IDLE, freezes stats)
//   i_err_clr, i_cnt_clr clear sticky errors / transaction counter
//   i_valid, i_ready     channel handshake
//   i_pld                channel payload
//   o_err_drop/pld/tmo   sticky error bits
//   o_txn_cnt            completed handshakes (saturating)
//   o_ev_code            error raised this cycle, highest priority only
module cache_chan_chk_lane
    import cache_chk_pkg::*;
#(
    parameter int PLD_WIDTH = DEF_PLD_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int WAIT_W    = clog2_min1(MAX_WAIT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_chk_en,
    input  logic                 i_err_clr,
    input  logic                 i_cnt_clr,
    input  logic                 i_valid,
    input  logic                 i_ready,
    input  logic [PLD_WIDTH-1:0] i_pld,
    output logic                 o_err_drop,
    output logic                 o_err_pld,
    output logic                 o_err_tmo,
    output logic [CNT_WIDTH-1:0] o_txn_cnt,
    output chk_err_e             o_ev_code
);

    localparam logic [WAIT_W-1:0] MAXW = WAIT_W'(MAX_WAIT);

    chk_state_e           r_state, w_state_nxt;
    logic [WAIT_W-1:0]    r_wait, w_wait_nxt, w_wait_inc;
    logic [PLD_WIDTH-1:0] r_cap, w_cap_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_drop, r_pld, r_tmo;
    logic                 w_ev_drop, w_ev_pld, w_ev_tmo, w_hs;

    assign w_wait_inc = r_wait + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_cap_nxt   = r_cap;
        w_ev_drop   = 1'b0;
        w_ev_pld    = 1'b0;
        w_ev_tmo    = 1'b0;
        w_hs        = 1'b0;
        if (!i_chk_en) begin
            // Disabled: forget any stall so re-enable starts a fresh episode.
            w_state_nxt = IDLE;
            w_wait_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        if (i_ready) begin
                            w_hs = 1'b1;
                        end else begin
                            w_cap_nxt   = i_pld;
                            w_wait_nxt  = WAIT_W'(1);
                            w_state_nxt = STALL;
                            if (MAX_WAIT == 1) w_ev_tmo = 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (!i_valid) begin
                        w_ev_drop   = 1'b1;
                        w_state_nxt = IDLE;
                        w_wait_nxt  = '0;
                    end else begin
                        // Original capture is kept even after a mismatch.
                        if (i_pld != r_cap) w_ev_pld = 1'b1;
                        if (i_ready) begin
                            w_hs        = 1'b1;
                            w_state_nxt = IDLE;
                            w_wait_nxt  = '0;
                        end else if (r_wait < MAXW) begin
                            // Saturation at MAXW makes the timeout one-shot.
                            w_wait_nxt = w_wait_inc;
                            if (w_wait_inc == MAXW) w_ev_tmo = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_wait_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wait  <= '0;
            r_cap   <= '0;
            r_drop  <= 1'b0;
            r_pld   <= 1'b0;
            r_tmo   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_cap   <= w_cap_nxt;
            // Clear first, then OR in new events so a same-cycle error survives.
            r_drop  <= (r_drop & ~i_err_clr) | w_ev_drop;
            r_pld   <= (r_pld  & ~i_err_clr) | w_ev_pld;
            r_tmo   <= (r_tmo  & ~i_err_clr) | w_ev_tmo;
            if (i_cnt_clr)
                r_cnt <= CNT_WIDTH'(w_hs);
            else if (w_hs && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_err_drop = r_drop;
    assign o_err_pld  = r_pld;
    assign o_err_tmo  = r_tmo;
    assign o_txn_cnt  = r_cnt;
    assign o_ev_code  = w_ev_drop ? ERR_DROP :
                        w_ev_pld  ? ERR_PLD  :
                        w_ev_tmo  ? ERR_TMO  : ERR_NONE;

endmodule

// File: rtl/cache_chan_proto_chk.sv
// Passive valid/ready protocol checker and transaction counter for NUM_CH
// cache-coherence channels.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   chk_en             checking/counting enable
//   err_clr, cnt_clr   clear sticky errors + first-error / clear counters
//   ch_valid/ready     per-channel handshake
//   ch_pld             payloads, channel i at [i*PLD_WIDTH +: PLD_WIDTH]
//   err_drop/pld/tmo   per-channel sticky errors; err_any is their OR
//   first_err_*        first error since reset/clear (lowest channel wins)
//   txn_cnt            per-channel completed handshakes, channel i at
//                      [i*CNT_WIDTH +: CNT_WIDTH]
module cache_chan_proto_chk
    import cache_chk_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int PLD_WIDTH = DEF_PLD_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int CH_IDX_W  = clog2_min1(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        chk_en,
    input  logic                        err_clr,
    input  logic                        cnt_clr,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH-1:0]           ch_ready,
    input  logic [NUM_CH*PLD_WIDTH-1:0] ch_pld,
    output logic [NUM_CH-1:0]           err_drop,
    output logic [NUM_CH-1:0]           err_pld,
    output logic [NUM_CH-1:0]           err_tmo,
    output logic                        err_any,
    output logic                        first_err_vld,
    output logic [CH_IDX_W-1:0]         first_err_ch,
    output logic [1:0]                  first_err_code,
    output logic [NUM_CH*CNT_WIDTH-1:0] txn_cnt
);

    chk_err_e            w_ev [NUM_CH];
    logic                w_hit;
    logic [CH_IDX_W-1:0] w_hit_ch;
    chk_err_e            w_hit_code;
    logic                r_fvld;
    logic [CH_IDX_W-1:0] r_fch;
    chk_err_e            r_fcode;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        cache_chan_chk_lane #(
            .PLD_WIDTH (PLD_WIDTH),
            .CNT_WIDTH (CNT_WIDTH),
            .MAX_WAIT  (MAX_WAIT)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_chk_en   (chk_en),
            .i_err_clr  (err_clr),
            .i_cnt_clr  (cnt_clr),
            .i_valid    (ch_valid[i]),
            .i_ready    (ch_ready[i]),
            .i_pld      (ch_pld[i*PLD_WIDTH +: PLD_WIDTH]),
            .o_err_drop (err_drop[i]),
            .o_err_pld  (err_pld[i]),
            .o_err_tmo  (err_tmo[i]),
            .o_txn_cnt  (txn_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
            .o_ev_code  (w_ev[i])
        );
    end

    // Scan high to low so the lowest erroring channel is the last writer.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_ch   = '0;
        w_hit_code = ERR_NONE;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_ev[i] != ERR_NONE) begin
                w_hit      = 1'b1;
                w_hit_ch   = CH_IDX_W'(i);
                w_hit_code = w_ev[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fvld  <= 1'b0;
            r_fch   <= '0;
            r_fcode <= ERR_NONE;
        end else if ((err_clr || !r_fvld) && w_hit) begin
            r_fvld  <= 1'b1;
            r_fch   <= w_hit_ch;
            r_fcode <= w_hit_code;
        end else if (err_clr) begin
            r_fvld  <= 1'b0;
            r_fch   <= '0;
            r_fcode <= ERR_NONE;
        end
    end

    assign err_any        = |{err_drop, err_pld, err_tmo};
    assign first_err_vld  = r_fvld;
    assign first_err_ch   = r_fch;
    assign first_err_code = r_fcode;

endmodule

// File: tb/tb_cache_chan_proto_chk.sv
module tb_cache_chan_proto_chk;

    localparam int NCH = 8;
    localparam int PW  = 16;
    localparam int CW  = 4;
    localparam int MW  = 4;
    localparam int IW  = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              chk_en = 1'b0, err_clr = 1'b0, cnt_clr = 1'b0;
    logic [NCH-1:0]    ch_valid = '0, ch_ready = '0;
    logic [NCH*PW-1:0] ch_pld = '0;
    logic [NCH-1:0]    err_drop, err_pld, err_tmo;
    logic              err_any, first_err_vld;
    logic [IW-1:0]     first_err_ch;
    logic [1:0]        first_err_code;
    logic [NCH*CW-1:0] txn_cnt;

    cache_chan_proto_chk #(
        .NUM_CH(NCH), .PLD_WIDTH(PW), .CNT_WIDTH(CW), .MAX_WAIT(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .err_clr(err_clr),
        .cnt_clr(cnt_clr), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_pld(ch_pld), .err_drop(err_drop), .err_pld(err_pld),
        .err_tmo(err_tmo), .err_any(err_any), .first_err_vld(first_err_vld),
        .first_err_ch(first_err_ch), .first_err_code(first_err_code),
        .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0]    drop, pld, tmo;
        logic              any, fvld;
        logic [IW-1:0]     fch;
        logic [1:0]        fcode;
        logic [NCH*CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int n_cmp = 0, n_bad = 0;

    // Reference model: a channel "owes" a transfer from the first cycle it
    // offers valid without ready until that transfer completes or valid falls.
    bit          m_owed [NCH];
    logic [PW-1:0] m_offer [NCH];
    int          m_waited [NCH];
    int          m_done [NCH];
    logic [NCH-1:0] m_drop, m_pld, m_tmo;
    bit          m_fvld;
    int          m_fch, m_fcode;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_owed[c] = 0; m_offer[c] = '0; m_waited[c] = 0; m_done[c] = 0;
        end
        m_drop = '0; m_pld = '0; m_tmo = '0;
        m_fvld = 0; m_fch = 0; m_fcode = 0;
    endtask

    task automatic model_edge();
        int code [NCH];
        exp_t e;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (err_clr) begin
                m_drop = '0; m_pld = '0; m_tmo = '0;
                m_fvld = 0; m_fch = 0; m_fcode = 0;
            end
            for (int c = 0; c < NCH; c++) begin
                bit v, r, ed, ep, et, done;
                logic [PW-1:0] p;
                v = ch_valid[c]; r = ch_ready[c]; p = ch_pld[c*PW +: PW];
                ed = 0; ep = 0; et = 0; done = 0;
                if (!chk_en) begin
                    m_owed[c] = 0; m_waited[c] = 0;
                end else if (m_owed[c]) begin
                    if (!v) begin
                        ed = 1; m_owed[c] = 0; m_waited[c] = 0;
                    end else begin
                        ep = (p != m_offer[c]);
                        if (r) begin
                            done = 1; m_owed[c] = 0; m_waited[c] = 0;
                        end else begin
                            m_waited[c]++;
                            et = (m_waited[c] == MW);
                        end
                    end
                end else if (v) begin
                    if (r) done = 1;
                    else begin
                        m_owed[c] = 1; m_offer[c] = p; m_waited[c] = 1;
                        et = (m_waited[c] == MW);
                    end
                end
                if (cnt_clr) m_done[c] = done;
                else         m_done[c] += done;
                m_drop[c] |= ed; m_pld[c] |= ep; m_tmo[c] |= et;
                code[c] = ed ? 1 : ep ? 2 : et ? 3 : 0;
            end
            if (!m_fvld) begin
                for (int c = 0; c < NCH; c++) begin
                    if (code[c] != 0) begin
                        m_fvld = 1; m_fch = c; m_fcode = code[c];
                        break;
                    end
                end
            end
        end
        e.drop = m_drop; e.pld = m_pld; e.tmo = m_tmo;
        e.any = |{m_drop, m_pld, m_tmo};
        e.fvld = m_fvld; e.fch = IW'(m_fch); e.fcode = 2'(m_fcode);
        for (int c = 0; c < NCH; c++)
            e.cnt[c*CW +: CW] = CW'((m_done[c] > CNT_MAX) ? CNT_MAX : m_done[c]);
        q.push_back(e);
    endtask

    // Inputs stay put across the edge; the model sees what the DUT sampled.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic set_ch(input int c, input bit v, input bit r, input logic [PW-1:0] p);
        ch_valid[c] = v;
        ch_ready[c] = r;
        ch_pld[c*PW +: PW] = p;
    endtask

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            cmp("err_drop",       64'(err_drop),       64'(mon_e.drop));
            cmp("err_pld",        64'(err_pld),        64'(mon_e.pld));
            cmp("err_tmo",        64'(err_tmo),        64'(mon_e.tmo));
            cmp("err_any",        64'(err_any),        64'(mon_e.any));
            cmp("first_err_vld",  64'(first_err_vld),  64'(mon_e.fvld));
            cmp("first_err_ch",   64'(first_err_ch),   64'(mon_e.fch));
            cmp("first_err_code", 64'(first_err_code), 64'(mon_e.fcode));
            cmp("txn_cnt",        64'(txn_cnt),        64'(mon_e.cnt));
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        step(); step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        // Clean stall then handshake on ch0.
        set_ch(0, 1, 0, 16'hA5); repeat (3) step();
        set_ch(0, 1, 1, 16'hA5); step();
        set_ch(0, 0, 0, 0);      step();

        // ch2 drops valid while stalled.
        set_ch(2, 1, 0, 16'h7); repeat (2) step();
        set_ch(2, 0, 0, 16'h7); step();

        // ch5 payload changes in the completing cycle.
        set_ch(5, 1, 0, 16'h10); step();
        set_ch(5, 1, 1, 16'h11); step();
        set_ch(5, 0, 0, 0);      step();

        // ch1 long stall: timeout fires once, transfer still completes.
        set_ch(1, 1, 0, 16'h3); repeat (10) step();
        set_ch(1, 1, 1, 16'h3); step();
        set_ch(1, 0, 0, 0);     step();

        // Simultaneous ch3 drop / ch6 pld, then clear with ch6 still erring.
        err_clr = 1'b1;
        set_ch(3, 1, 0, 16'h33); set_ch(6, 1, 0, 16'h66); step();
        err_clr = 1'b0;
        set_ch(3, 0, 0, 16'h33); set_ch(6, 1, 0, 16'h67); step();
        err_clr = 1'b1; step();
        err_clr = 1'b0;
        set_ch(6, 1, 1, 16'h67); step();
        set_ch(6, 0, 0, 0);      step();

        // ch7 counter saturation, then clear with a concurrent handshake.
        for (int i = 0; i < 20; i++) begin
            set_ch(7, 1, 1, PW'(i)); step();
        end
        cnt_clr = 1'b1; step();
        cnt_clr = 1'b0;
        set_ch(7, 0, 0, 0); step();

        // Disable mid-stall, change payload while disabled, re-enable.
        set_ch(4, 1, 0, 16'h1); repeat (2) step();
        chk_en = 1'b0;
        set_ch(4, 1, 0, 16'h2); repeat (2) step();
        set_ch(4, 0, 0, 16'h2); step();
        set_ch(4, 1, 0, 16'h2); step();
        chk_en = 1'b1; step();
        set_ch(4, 1, 1, 16'h2); step();
        set_ch(4, 0, 0, 0);     step();

        // Reset while a stall is open.
        set_ch(0, 1, 0, 16'h9); repeat (2) step();
        pulse_reset();
        set_ch(0, 1, 1, 16'h9); step();
        set_ch(0, 0, 0, 0);     step();

        // Randomised traffic: mostly compliant with occasional violations.
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) begin
                bit stl, v, r;
                logic [PW-1:0] p;
                stl = ch_valid[c] && !ch_ready[c];
                p = ch_pld[c*PW +: PW];
                if (stl) begin
                    v = ($urandom_range(0, 19) != 0);
                    if ($urandom_range(0, 15) == 0) p = PW'($urandom_range(0, 3));
                end else begin
                    v = $urandom_range(0, 1);
                    p = PW'($urandom_range(0, 3));
                end
                r = ($urandom_range(0, 2) == 0);
                set_ch(c, v, r, p);
            end
            chk_en  = ($urandom_range(0, 39) != 0);
            err_clr = ($urandom_range(0, 24) == 0);
            cnt_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else step();
        end

        chk_en = 1'b1; err_clr = 1'b0; cnt_clr = 1'b0;
        ch_valid = '0; ch_ready = '0;
        step(); step();
        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
